// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
`timescale 1ns/1ps
package uart_pkg;
   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      CLEANUP
   } state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial pin in, byte strobe and status out.
`timescale 1ns/1ps
interface uart_rx_if;
   import uart_pkg::*;

   // o_RX_DV is a valid-only strobe with no ready: the consumer must take
   // o_RX_Byte in the DV cycle or rely on it being held until the next good frame.
   logic                 i_RX_Serial;
   logic                 o_RX_DV;
   logic [DATA_BITS-1:0] o_RX_Byte;
   logic                 o_RX_Frame_Err;
   state_e               state_dbg;

   modport slave (
      input  i_RX_Serial,
      output o_RX_DV, o_RX_Byte, o_RX_Frame_Err, state_dbg
   );

   modport master (
      output i_RX_Serial,
      input  o_RX_DV, o_RX_Byte, o_RX_Frame_Err, state_dbg
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);
   logic meta;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta   <= RESET_VAL;
         o_Sync <= RESET_VAL;
      end else begin
         meta   <= i_Async;
         o_Sync <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples every bit mid-period relative to the start edge.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic      i_Clock,
   input  logic      i_Reset,
   uart_rx_if.slave  rx_if
);
   localparam int                CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic                 rx_s;
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 dv_q, dv_d;
   logic                 err_q, err_d;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (rx_if.i_RX_Serial),
      .o_Sync  (rx_s)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         dv_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         dv_q       <= dv_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      dv_d       = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // A line back high at mid-start was a glitch, not a frame.
            if (clk_cnt_q == HALF) begin
               clk_cnt_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (clk_cnt_q == LAST) begin
               clk_cnt_d             = '0;
               rx_shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
               else bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (clk_cnt_q == LAST) begin
               clk_cnt_d = '0;
               state_d   = CLEANUP;
               if (rx_s) begin
                  rx_byte_d = rx_shift_q;
                  dv_d      = 1'b1;
               end else begin
                  err_d     = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         CLEANUP: begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_if.o_RX_DV        = dv_q;
   assign rx_if.o_RX_Frame_Err = err_q;
   assign rx_if.o_RX_Byte      = rx_byte_q;
   assign rx_if.state_dbg      = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized timing, scoreboard-checked.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 217;
  localparam int BIT_NS = 8680;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Entry: {is_frame_err, byte that o_RX_Byte must show in the strobe cycle}
  logic [8:0] exp_q[$];
  logic [7:0] model_byte = 8'h00;
  bit         prev_out = 1'b0;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx_if   (bus)
  );

  always #20 clk = ~clk;

  initial begin
    #3_800_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Frame driver; when track is set the expected response is derived here
  // from the 8N1 rules and queued for the monitor.
  task automatic send_frame(input logic [7:0] b, input int start_ns, input int bit_ns,
                            input logic stop_v, input bit track);
    if (track) begin
      if (stop_v) begin
        model_byte = b;
        exp_q.push_back({1'b0, b});
      end else begin
        exp_q.push_back({1'b1, model_byte});
      end
    end
    bus.i_RX_Serial = 1'b0;
    #(start_ns);
    for (int i = 0; i < 8; i++) begin
      bus.i_RX_Serial = b[i];
      #(bit_ns);
    end
    bus.i_RX_Serial = stop_v;
    #(bit_ns);
    bus.i_RX_Serial = 1'b1;
  endtask

  task automatic drain_and_check(input string name);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
    check({name, "_byte"}, bus.o_RX_Byte, model_byte);
  endtask

  // Monitor: pops an expectation on every strobe and enforces one-cycle pulses.
  always @(negedge clk) begin
    logic [8:0] e;
    bit cur_out;
    cur_out = bus.o_RX_DV || bus.o_RX_Frame_Err;
    if (prev_out) check("pulse_width", cur_out, 0);
    if (cur_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: dv=%0b err=%0b byte=%h, required no output",
                 bus.o_RX_DV, bus.o_RX_Frame_Err, bus.o_RX_Byte);
      end else begin
        e = exp_q.pop_front();
        check("strobe", {bus.o_RX_DV, bus.o_RX_Frame_Err, bus.o_RX_Byte},
              {~e[8], e[8], e[7:0]});
      end
    end
    prev_out = cur_out;
  end

  initial begin
    int bit_ns, start_ns, gap_ns;
    logic [7:0] rb;

    bus.i_RX_Serial = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dv", bus.o_RX_DV, 0);
    check("reset_err", bus.o_RX_Frame_Err, 0);
    check("reset_byte", bus.o_RX_Byte, 8'h00);
    check("reset_state", bus.state_dbg, IDLE);

    // Slightly long start bit, slightly short data bits
    send_frame(8'h37, 9600, 8600, 1'b1, 1'b1);
    drain_and_check("f37");

    #1_000_000;
    check("hold_37", bus.o_RX_Byte, 8'h37);
    @(negedge clk);
    send_frame(8'd25, 9600, 8600, 1'b1, 1'b1);
    drain_and_check("f19");

    // Short low glitch must be rejected at mid-start
    @(negedge clk);
    bus.i_RX_Serial = 1'b0;
    repeat (50) @(negedge clk);
    bus.i_RX_Serial = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_state", bus.state_dbg, IDLE);
    check("glitch_byte", bus.o_RX_Byte, 8'h19);

    send_frame(8'hA5, BIT_NS, BIT_NS, 1'b0, 1'b1);
    drain_and_check("ferr");
    repeat (300) @(negedge clk);
    send_frame(8'h5A, BIT_NS, BIT_NS, 1'b1, 1'b1);
    drain_and_check("f5a");

    // Reset in the middle of data bit 4 aborts the frame silently
    repeat (100) @(negedge clk);
    fork
      send_frame(8'hFF, BIT_NS, BIT_NS, 1'b1, 1'b0);
      begin
        #(BIT_NS * 5 + BIT_NS / 2);
        @(negedge clk);
        rst = 1'b1;
        model_byte = 8'h00;
        @(negedge clk);
        check("midrst_byte", bus.o_RX_Byte, 8'h00);
        check("midrst_dv", bus.o_RX_DV, 0);
        check("midrst_state", bus.state_dbg, IDLE);
        rst = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    check("midrst_hold", bus.o_RX_Byte, 8'h00);
    send_frame(8'h81, BIT_NS, BIT_NS, 1'b1, 1'b1);
    drain_and_check("f81");

    // Back-to-back frames, no idle time after the first stop bit
    repeat (50) @(negedge clk);
    send_frame(8'h00, BIT_NS, BIT_NS, 1'b1, 1'b1);
    send_frame(8'hFF, BIT_NS, BIT_NS, 1'b1, 1'b1);
    drain_and_check("b2b");

    // Random bytes with a few percent of bit-period error and stretched starts
    for (int n = 0; n < 6; n++) begin
      rb       = 8'($urandom_range(0, 255));
      bit_ns   = BIT_NS - 150 + int'($urandom_range(0, 300));
      start_ns = bit_ns + int'($urandom_range(0, bit_ns / 5));
      gap_ns   = int'($urandom_range(0, 20000));
      #(gap_ns);
      @(negedge clk);
      send_frame(rb, start_ns, bit_ns, 1'b1, 1'b1);
      drain_and_check("rand");
    end

    repeat (20) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
